router_nport: RTL and testbench

- Parametrised successor of the 3-port packet router: one ingress byte stream is steered to NUM_PORTS output FIFOs by header address.
- Single module containing the ingress FSM, header/parity registers, per-port FIFOs and per-port soft-reset timers.
- Beyond the current router: configurable width, depth and port count, dropping of packets with an invalid address, payload-length checking, and optional broadcast.

---
 rtl/router_nport.sv | 241 ++++++++++++++++++++++++
 tb/tb_router_nport.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/router_nport.sv
// router_nport: steers one ingress byte stream into NUM_PORTS output FIFOs selected by the header address.
// Latency: header lands in its FIFO on its acceptance edge when the target is empty; read data appears 1 cycle after read_enb.
// Backpressure: busy stalls the source (data_in held) in WAIT_EMPTY, CHECK, and in LOAD_DATA while the target FIFO is full.
//
// Ports:
//   clock, resetn          single rising-edge clock, asynchronous active-low reset
//   pkt_valid, data_in     ingress stream; pkt_valid=0 marks the trailing parity byte
//   read_enb[p]            per-port pop request, ignored when the FIFO is empty
//   data_out[p*DW +: DW]   per-port registered read data, held between reads
//   valid_out[p]           per-port FIFO non-empty
//   busy                   ingress stall
//   error                  one-cycle pulse on parity or payload-length mismatch
//   drop                   one-cycle pulse when a packet with an invalid address ends
// Optional feature: define ROUTER_BROADCAST_EN to treat addr 2'b11 as broadcast to every port.
module router_nport #(
    parameter int NUM_PORTS = 3,
    parameter int DW        = 8,
    parameter int DEPTH     = 16,
    parameter int TIMEOUT   = 30
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    pkt_valid,
    input  logic [DW-1:0]           data_in,
    input  logic [NUM_PORTS-1:0]    read_enb,
    output logic [NUM_PORTS*DW-1:0] data_out,
    output logic [NUM_PORTS-1:0]    valid_out,
    output logic                    busy,
    output logic                    error,
    output logic                    drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = DW - 2;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DROP  = 3'd4;

    typedef struct packed {
        logic [LW-1:0] len;
        logic [1:0]    addr;
    } hdr_t;

    if (NUM_PORTS < 2 || NUM_PORTS > 4 || DW < 8 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0)
    begin : g_bad_param
        $error("router_nport: illegal NUM_PORTS/DW/DEPTH combination");
    end

    // ------------------------------------------------------------------
    // Ingress control state
    // ------------------------------------------------------------------
    logic [2:0]    state_q, state_d;
    hdr_t          hdr_q, hdr_d;
    logic [DW-1:0] par_q, par_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          mis_q, mis_d;
    logic          drop_q, drop_d;

    hdr_t                 hdr_in;
    logic [1:0]           addr;
    logic                 bcast;
    logic                 addr_ok;
    logic [NUM_PORTS-1:0] sel;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] wr_en;
    logic [NUM_PORTS-1:0] rd_en;
    logic [NUM_PORTS-1:0] flush;
    logic                 tgt_empty;
    logic                 tgt_full;
    logic                 accept;
    logic                 wr_any;
    logic [DW-1:0]        wdata;

    assign hdr_in = data_in;

    // In IDLE the incoming byte is the header, so route on it directly;
    // afterwards the captured header decides the destination.
    assign addr = (state_q == S_IDLE) ? hdr_in.addr : hdr_q.addr;

`ifdef ROUTER_BROADCAST_EN
    if (NUM_PORTS == 4) begin : g_bad_bcast
        $error("router_nport: broadcast address 2'b11 collides with port 3");
    end
    assign bcast = (addr == 2'b11);
`else
    assign bcast = 1'b0;
`endif

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_sel
        assign sel[p] = bcast || (addr == 2'(p));
    end

    assign addr_ok   = ({1'b0, addr} < 3'(NUM_PORTS)) || bcast;
    // All selected FIFOs must be empty to start; any selected full FIFO stalls.
    assign tgt_empty = &(empty | ~sel);
    assign tgt_full  = |(full & sel);

    always_comb begin
        busy = 1'b0;
        case (state_q)
            S_WAIT:  busy = 1'b1;
            S_LOAD:  busy = tgt_full;
            S_CHECK: busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign accept = !busy && (((state_q == S_IDLE) && pkt_valid) ||
                              (state_q == S_LOAD) || (state_q == S_DROP));

    assign wr_any = ((state_q == S_IDLE) && pkt_valid && addr_ok && tgt_empty) ||
                    ((state_q == S_WAIT) && tgt_empty) ||
                    ((state_q == S_LOAD) && !busy);

    // A header parked in WAIT_EMPTY is replayed from hdr_q; everything else streams through.
    assign wdata = (state_q == S_WAIT) ? hdr_q : data_in;
    assign wr_en = sel & {NUM_PORTS{wr_any}};

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        par_d   = par_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        drop_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pkt_valid) begin
                    hdr_d = hdr_in;
                    par_d = data_in;
                    cnt_d = '0;
                    if (!addr_ok)       state_d = S_DROP;
                    else if (tgt_empty) state_d = S_LOAD;
                    else                state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tgt_empty) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (accept) begin
                    if (pkt_valid) begin
                        par_d = par_q ^ data_in;
                        if (cnt_q != '1) cnt_d = cnt_q + LW'(1);
                    end else begin
                        mis_d   = (data_in != par_q) || (cnt_q != hdr_q.len);
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: state_d = S_IDLE;
            S_DROP: begin
                if (!pkt_valid) begin
                    drop_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            hdr_q   <= '0;
            par_q   <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            par_q   <= par_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            drop_q  <= drop_d;
        end
    end

    assign error = (state_q == S_CHECK) && mis_q;
    assign drop  = drop_q;

    // ------------------------------------------------------------------
    // Per-port FIFO with registered read data and stale-data timer
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [DW-1:0] mem_q [DEPTH];
        logic [AW-1:0] wp_q, rp_q;
        logic [AW:0]   fcnt_q;
        logic [DW-1:0] dout_q;
        logic [TW-1:0] tmr_q, tmr_d;
        logic          stale;

        assign empty[p] = (fcnt_q == '0);
        assign full[p]  = (fcnt_q == (AW+1)'(DEPTH));
        assign rd_en[p] = read_enb[p] && !empty[p];

        // Timer runs only while data sits unread; the TIMEOUT-th such cycle flushes.
        assign stale    = !empty[p] && !read_enb[p];
        assign flush[p] = stale && (tmr_q == TW'(TIMEOUT - 1));
        assign tmr_d    = (stale && !flush[p]) ? tmr_q + TW'(1) : '0;

        // A flush beats a same-cycle write: the byte is lost, pointers restart at 0.
        always_ff @(posedge clock) begin
            if (wr_en[p] && !flush[p]) mem_q[wp_q] <= wdata;
        end

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                wp_q   <= '0;
                rp_q   <= '0;
                fcnt_q <= '0;
                dout_q <= '0;
                tmr_q  <= '0;
            end else if (flush[p]) begin
                wp_q   <= '0;
                rp_q   <= '0;
                fcnt_q <= '0;
                dout_q <= '0;
                tmr_q  <= '0;
            end else begin
                tmr_q <= tmr_d;
                if (wr_en[p]) wp_q <= wp_q + AW'(1);
                if (rd_en[p]) begin
                    dout_q <= mem_q[rp_q];
                    rp_q   <= rp_q + AW'(1);
                end
                fcnt_q <= fcnt_q + (AW+1)'(wr_en[p]) - (AW+1)'(rd_en[p]);
            end
        end

        assign data_out[p*DW +: DW] = dout_q;
        assign valid_out[p]         = !empty[p];
    end

endmodule

// File: tb/tb_router_nport.sv
// tb_router_nport: directed scoreboard bench for router_nport (3 ports, 8-bit, 16-deep, timeout 30).
// Latency: expected bytes queued per port on acceptance, compared when the 1-cycle read data appears.
// Backpressure: the source offers each byte until busy is seen low across a rising edge.
module tb_router_nport;

    logic        clock = 1'b0;
    logic        resetn;
    logic        pkt_valid;
    logic [7:0]  data_in;
    logic [2:0]  read_enb;
    logic [23:0] data_out;
    logic [2:0]  valid_out;
    logic        busy;
    logic        error;
    logic        drop;

    int checks   = 0;
    int failures = 0;
    int err_cnt, drop_cnt, busy_cnt, n_rd;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [8:0] pkt_q[$];
    logic [7:0] par;

    router_nport #(
        .NUM_PORTS(3),
        .DW(8),
        .DEPTH(16),
        .TIMEOUT(30)
    ) u_dut (
        .clock    (clock),
        .resetn   (resetn),
        .pkt_valid(pkt_valid),
        .data_in  (data_in),
        .read_enb (read_enb),
        .data_out (data_out),
        .valid_out(valid_out),
        .busy     (busy),
        .error    (error),
        .drop     (drop)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push(input logic [2:0] m, input logic [7:0] d);
        if (m[0]) q0.push_back(d);
        if (m[1]) q1.push_back(d);
        if (m[2]) q2.push_back(d);
    endfunction

    function automatic logic [7:0] pop(input int p);
        logic [7:0] d;
        d = 8'hxx;
        case (p)
            0: if (q0.size() != 0) d = q0.pop_front();
            1: if (q1.size() != 0) d = q1.pop_front();
            default: if (q2.size() != 0) d = q2.pop_front();
        endcase
        return d;
    endfunction

    task automatic pkt_hdr(input logic [7:0] h);
        pkt_q.push_back({1'b1, h});
        par = h;
    endtask

    task automatic pkt_pay(input logic [7:0] d);
        pkt_q.push_back({1'b1, d});
        par = par ^ d;
    endtask

    task automatic pkt_par();
        pkt_q.push_back({1'b0, par});
    endtask

    task automatic pkt_raw_par(input logic [7:0] p);
        pkt_q.push_back({1'b0, p});
    endtask

    // Streams pkt_q into the DUT (pushing accepted bytes to the ports in push_m),
    // reads the ports in rd_m every cycle, and checks each returned byte.
    // limit>=0 stops after that many accepted bytes with the next byte held on data_in.
    task automatic xfer(input logic [2:0] push_m, input logic [2:0] rd_m, input int limit);
        int         done;
        int         cyc;
        int         tail;
        logic       take;
        logic [2:0] rd_now;
        done = 0; cyc = 0; tail = 0;
        err_cnt = 0; drop_cnt = 0; busy_cnt = 0; n_rd = 0;
        while (cyc < 400) begin
            if (pkt_q.size() != 0) begin
                pkt_valid = pkt_q[0][8];
                data_in   = pkt_q[0][7:0];
            end else begin
                pkt_valid = 1'b0;
                data_in   = 8'h00;
            end
            if (limit >= 0 && done >= limit) break;
            if (pkt_q.size() == 0 && (valid_out & rd_m) == 3'b000) begin
                if (tail == 2) break;
                tail++;
            end
            take     = (pkt_q.size() != 0) && !busy;
            rd_now   = rd_m & valid_out;
            read_enb = rd_m;
            if (busy) busy_cnt++;
            @(negedge clock);
            cyc++;
            if (error) err_cnt++;
            if (drop)  drop_cnt++;
            for (int p = 0; p < 3; p++) begin
                if (rd_now[p]) begin
                    n_rd++;
                    chk($sformatf("rd_port%0d", p), {24'h0, data_out[p*8 +: 8]}, {24'h0, pop(p)});
                end
            end
            if (take) begin
                push(push_m, pkt_q[0][7:0]);
                void'(pkt_q.pop_front());
                done++;
            end
        end
        read_enb = 3'b000;
        if (cyc >= 400) begin
            checks++;
            failures++;
            $error("FAIL xfer_timeout cycles=%0d pending=%0d", cyc, pkt_q.size());
        end
    endtask

    initial begin
        resetn    = 1'b0;
        pkt_valid = 1'b0;
        data_in   = 8'h00;
        read_enb  = 3'b000;
        #3;
        chk("rst_data_out",  data_out,  0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_error",     error,     0);
        chk("rst_drop",      drop,      0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // Port 1, len 3, correct parity; held unread, then drained.
        pkt_hdr(8'h0D); pkt_pay(8'h11); pkt_pay(8'h22); pkt_pay(8'h33); pkt_par();
        xfer(3'b010, 3'b000, -1);
        chk("p1_error", err_cnt, 0);
        chk("p1_valid", valid_out, 3'b010);
        xfer(3'b000, 3'b010, -1);
        chk("p1_reads", n_rd, 5);
        chk("p1_empty", valid_out, 3'b000);

        // Same packet, wrong parity byte.
        pkt_hdr(8'h0D); pkt_pay(8'h11); pkt_pay(8'h22); pkt_pay(8'h33); pkt_raw_par(8'h00);
        xfer(3'b010, 3'b010, -1);
        chk("bad_par_error_cycles", err_cnt, 1);

        // Header claims len 4, only 3 payload bytes, parity otherwise correct.
        pkt_hdr(8'h11); pkt_pay(8'h01); pkt_pay(8'h02); pkt_pay(8'h03); pkt_par();
        xfer(3'b010, 3'b010, -1);
        chk("short_len_error_cycles", err_cnt, 1);

`ifdef ROUTER_BROADCAST_EN
        // Port 0 left occupied, then a broadcast that must wait for it to drain.
        pkt_hdr(8'h00); pkt_par();
        xfer(3'b001, 3'b000, -1);
        chk("pre_bcast_error", err_cnt, 0);
        pkt_hdr(8'h07); pkt_pay(8'hAA); pkt_par();
        xfer(3'b111, 3'b111, -1);
        chk("bcast_busy_seen", busy_cnt > 0, 1);
        chk("bcast_reads", n_rd, 11);
        chk("bcast_error", err_cnt, 0);
        chk("bcast_empty", valid_out, 3'b000);
`else
        // Address 3 with three ports is dropped.
        pkt_hdr(8'h07); pkt_pay(8'h55); pkt_par();
        xfer(3'b000, 3'b000, -1);
        chk("drop_cycles", drop_cnt, 1);
        chk("drop_busy",   busy_cnt, 0);
        chk("drop_error",  err_cnt,  0);
        chk("drop_no_wr",  valid_out, 3'b000);
`endif

        // Port 0, len 20: fills the 16-deep FIFO and stalls the source.
        pkt_hdr(8'h50);
        for (int i = 0; i < 20; i++) pkt_pay(8'(i * 7 + 1));
        pkt_par();
        xfer(3'b001, 3'b000, 16);
        chk("bp_busy_full", busy, 1);
        repeat (3) @(negedge clock);
        chk("bp_busy_hold", busy, 1);
        chk("bp_valid", valid_out, 3'b001);
        read_enb = 3'b001;
        @(negedge clock);
        read_enb = 3'b000;
        chk("bp_one_read", {24'h0, data_out[7:0]}, {24'h0, pop(0)});
        chk("bp_busy_freed", busy, 0);
        xfer(3'b001, 3'b000, 1);
        chk("bp_busy_again", busy, 1);
        xfer(3'b001, 3'b001, -1);
        chk("bp_error", err_cnt, 0);
        chk("bp_empty", valid_out, 3'b000);

        // Port 2, len 0: a read inside the window restarts the timer, then it flushes.
        pkt_hdr(8'h02); pkt_par();
        xfer(3'b100, 3'b000, -1);
        chk("len0_error", err_cnt, 0);
        repeat (20) @(negedge clock);
        read_enb = 3'b100;
        @(negedge clock);
        read_enb = 3'b000;
        chk("to_read", {24'h0, data_out[23:16]}, {24'h0, pop(2)});
        repeat (29) @(negedge clock);
        chk("to_not_yet", valid_out[2], 1);
        @(negedge clock);
        chk("to_flushed_valid", valid_out[2], 0);
        chk("to_flushed_data", {24'h0, data_out[23:16]}, 0);
        q2.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
